player_motion_ctrl: RTL and testbench

- Parametrised per-player motion and life controller, updated once per frame.
- One instance per player.
- Decodes left/right keys from N keycode slots and moves the player horizontally with a same-frame clamp to level-dependent walls.
- Runs a hit/freeze/invulnerability/death state machine with a lives counter.
- Feeds the sprite renderer (x, facing, blink) and game control (lives, dead). Pixel drawing is out of scope.

---
 rtl/player_pkg.sv | 21 ++
 rtl/player_motion_ctrl_key_match.sv | 19 +
 rtl/player_motion_ctrl.sv | 157 +++++++++++++++
 tb/tb_player_motion_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and screen constants for the per-player motion/life controller.
package player_pkg;

  typedef enum logic [1:0] {
    FWD   = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } facing_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    HIT    = 3'd2,
    INVULN = 3'd3,
    DEAD   = 3'd4
  } pstate_t;

  localparam int X_MIN = 10;
  localparam int X_MAX = 590;

endpackage

// File: rtl/player_motion_ctrl_key_match.sv
// Reports whether a non-zero target keycode appears in any of the packed keycode slots.
module key_match #(
  parameter int NUM_KEYS = 4
) (
  input  logic [NUM_KEYS*8-1:0] keycodes_i,
  input  logic [7:0]            target_i,
  output logic                  hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keycodes_i[8*i +: 8] == target_i) hit_o = 1'b1;
    end
    // Code 0 means "empty slot", so it can never count as a press.
    if (target_i == 8'd0) hit_o = 1'b0;
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player frame-rate controller: horizontal motion with wall clamping plus the
// hit / freeze / invulnerability / death state machine and lives counter.
module player_motion_ctrl #(
  parameter int          NUM_KEYS        = 4,
  parameter int          X_CENTER        = 380,
  parameter int          X_MIN           = player_pkg::X_MIN,
  parameter int          X_MIN_WALL      = 130,
  parameter int          X_MAX           = player_pkg::X_MAX,
  parameter int          SPRITE_W        = 43,
  parameter int          STEP            = 2,
  parameter logic [15:0] WALL_LEVEL_MASK = 16'h0070,
  parameter int          LIVES_INIT      = 3,
  parameter int          FREEZE_FRAMES   = 60,
  parameter int          INVULN_FRAMES   = 120
) (
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [NUM_KEYS*8-1:0] keycodes,
  input  logic [7:0]            key_left,
  input  logic [7:0]            key_right,
  input  logic [9:0]            level,
  input  logic [1:0]            game_on,
  input  logic                  collision,
  input  logic                  enable,
  output logic [9:0]            player_x,
  output logic [1:0]            facing,
  output logic [2:0]            pstate,
  output logic                  invuln,
  output logic                  blink,
  output logic [2:0]            lives,
  output logic                  dead
);
  import player_pkg::*;

  localparam int TMAX    = (FREEZE_FRAMES > INVULN_FRAMES) ? FREEZE_FRAMES : INVULN_FRAMES;
  localparam int TIMER_W = (TMAX > 8) ? $clog2(TMAX + 1) : 3;

  pstate_t              state_q, state_d;
  logic [9:0]           x_q, x_d;
  logic [2:0]           lives_q, lives_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  logic left_p, right_p;

  key_match #(.NUM_KEYS(NUM_KEYS)) u_left_match (
    .keycodes_i (keycodes),
    .target_i   (key_left),
    .hit_o      (left_p)
  );

  key_match #(.NUM_KEYS(NUM_KEYS)) u_right_match (
    .keycodes_i (keycodes),
    .target_i   (key_right),
    .hit_o      (right_p)
  );

  logic                wall;
  logic signed [10:0]  xmin_s, xmax_s, x_s, x_left_s, x_right_s, nx_left_s, nx_right_s;
  logic                move_ok;
  logic [9:0]          x_move;
  facing_t             face;

  // Clamp against this frame's bounds at 11-bit signed so a step below zero cannot wrap.
  always_comb begin
    wall       = (level < 10'd16) && WALL_LEVEL_MASK[level[3:0]];
    xmin_s     = wall ? $signed(11'(X_MIN_WALL)) : $signed(11'(X_MIN));
    xmax_s     = $signed(11'(X_MAX - SPRITE_W));
    x_s        = $signed({1'b0, x_q});
    x_left_s   = x_s - $signed(11'(STEP));
    x_right_s  = x_s + $signed(11'(STEP));
    nx_left_s  = (x_left_s < xmin_s) ? xmin_s : x_left_s;
    nx_right_s = (x_right_s > xmax_s) ? xmax_s : x_right_s;
  end

  always_comb begin
    move_ok = (game_on != 2'd0) && enable && ((state_q == ACTIVE) || (state_q == INVULN));
    x_move  = x_q;
    face    = FWD;
    if (move_ok) begin
      if (left_p) begin
        x_move = nx_left_s[9:0];
        if (nx_left_s != x_s) face = LEFT;
      end else if (right_p) begin
        x_move = nx_right_s[9:0];
        if (nx_right_s != x_s) face = RIGHT;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    lives_d = lives_q;
    timer_d = timer_q;
    if (game_on == 2'd0) begin
      state_d = IDLE;
      x_d     = 10'(X_CENTER);
      lives_d = 3'(LIVES_INIT);
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ACTIVE;
        ACTIVE: begin
          x_d = x_move;
          if (enable && collision) begin
            if (lives_q <= 3'd1) begin
              state_d = DEAD;
              lives_d = 3'd0;
            end else begin
              state_d = HIT;
              lives_d = lives_q - 3'd1;
              timer_d = TIMER_W'(FREEZE_FRAMES - 1);
            end
          end
        end
        HIT: begin
          if (timer_q == '0) begin
            state_d = INVULN;
            timer_d = TIMER_W'(INVULN_FRAMES - 1);
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        INVULN: begin
          x_d = x_move;
          if (timer_q == '0) state_d = ACTIVE;
          else               timer_d = timer_q - 1'b1;
        end
        DEAD: state_d = DEAD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= 10'(X_CENTER);
      lives_q <= 3'(LIVES_INIT);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
    end
  end

  assign player_x = x_q;
  assign lives    = lives_q;
  assign pstate   = state_q;
  assign facing   = face;
  assign invuln   = (state_q == HIT) || (state_q == INVULN);
  assign blink    = (state_q == INVULN) && timer_q[2];
  assign dead     = (state_q == DEAD);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: vector table for the basic frames, then
// hand-written sequences for walls, clamps, hit/invuln timing, death and reset.
module tb_player_motion_ctrl;

  localparam int S_IDLE = 0, S_ACTIVE = 1, S_HIT = 2, S_INVULN = 3, S_DEAD = 4;
  localparam int F_FWD = 0, F_LEFT = 1, F_RIGHT = 2;
  localparam logic [31:0] K_NONE = 32'h0000_0000;
  localparam logic [31:0] K_L    = 32'h0050_0000;
  localparam logic [31:0] K_R    = 32'h0000_004F;
  localparam logic [31:0] K_LR   = 32'h0050_004F;

  logic        Reset, frame_clk;
  logic [31:0] keycodes;
  logic [7:0]  key_left, key_right;
  logic [9:0]  level;
  logic [1:0]  game_on;
  logic        collision, enable;
  logic [9:0]  player_x;
  logic [1:0]  facing;
  logic [2:0]  pstate;
  logic        invuln, blink;
  logic [2:0]  lives;
  logic        dead;

  int checks = 0;
  int errors = 0;

  player_motion_ctrl dut (
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .keycodes  (keycodes),
    .key_left  (key_left),
    .key_right (key_right),
    .level     (level),
    .game_on   (game_on),
    .collision (collision),
    .enable    (enable),
    .player_x  (player_x),
    .facing    (facing),
    .pstate    (pstate),
    .invuln    (invuln),
    .blink     (blink),
    .lives     (lives),
    .dead      (dead)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] keys;
    logic [9:0]  lvl;
    logic [1:0]  gon;
    logic        col;
    logic        en;
    int          x;
    int          fac;
    int          lv;
    int          st;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame(input logic [31:0] k, input logic [9:0] lv, input logic [1:0] g,
                       input logic c, input logic e);
    keycodes  = k;
    level     = lv;
    game_on   = g;
    collision = c;
    enable    = e;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int x, input int f, input int lv, input int st);
    chk({tag, " x"},      32'(player_x), 32'(x));
    chk({tag, " facing"}, 32'(facing),   32'(f));
    chk({tag, " lives"},  32'(lives),    32'(lv));
    chk({tag, " pstate"}, 32'(pstate),   32'(st));
    chk({tag, " invuln"}, 32'(invuln),   32'((st == S_HIT) || (st == S_INVULN)));
    chk({tag, " dead"},   32'(dead),     32'(st == S_DEAD));
    if (st != S_INVULN) chk({tag, " blink"}, 32'(blink), 32'd0);
  endtask

  initial begin
    int ex_x;
    int ex_t;

    tbl[0] = '{K_NONE, 10'd1, 2'd1, 1'b0, 1'b1, 380, F_FWD, 3, S_ACTIVE};
    for (int i = 1; i <= 10; i++)
      tbl[i] = '{K_L, 10'd1, 2'd1, 1'b0, 1'b1, 380 - 2 * i, F_LEFT, 3, S_ACTIVE};
    tbl[11] = '{K_NONE, 10'd1, 2'd1, 1'b0, 1'b1, 360, F_FWD,   3, S_ACTIVE};
    tbl[12] = '{K_L,    10'd1, 2'd1, 1'b1, 1'b0, 360, F_FWD,   3, S_ACTIVE};
    tbl[13] = '{K_R,    10'd1, 2'd1, 1'b0, 1'b1, 362, F_RIGHT, 3, S_ACTIVE};
    tbl[14] = '{K_L,    10'd1, 2'd1, 1'b0, 1'b1, 360, F_LEFT,  3, S_ACTIVE};

    Reset = 1'b1; keycodes = K_NONE; key_left = 8'h50; key_right = 8'h4F;
    level = 10'd1; game_on = 2'd0; collision = 1'b0; enable = 1'b1;
    #12;
    expect_out("reset", 380, F_FWD, 3, S_IDLE);
    Reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      frame(tbl[i].keys, tbl[i].lvl, tbl[i].gon, tbl[i].col, tbl[i].en);
      expect_out($sformatf("vec%0d", i), tbl[i].x, tbl[i].fac, tbl[i].lv, tbl[i].st);
    end

    // Walk left at level 1 down to x=134.
    for (int i = 1; i <= 113; i++) begin
      frame(K_L, 10'd1, 2'd1, 1'b0, 1'b1);
      chk("walk_left x", 32'(player_x), 32'(360 - 2 * i));
    end
    // Wall level: stops at 130 and faces forward.
    frame(K_L, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("wall1", 132, F_LEFT, 3, S_ACTIVE);
    frame(K_L, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("wall2", 130, F_FWD, 3, S_ACTIVE);
    frame(K_L, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("wall3", 130, F_FWD, 3, S_ACTIVE);
    // No wall: back to 134 then down to the screen limit of 10.
    frame(K_R, 10'd1, 2'd1, 1'b0, 1'b1); expect_out("nowall_r1", 132, F_RIGHT, 3, S_ACTIVE);
    frame(K_R, 10'd1, 2'd1, 1'b0, 1'b1); expect_out("nowall_r2", 134, F_RIGHT, 3, S_ACTIVE);
    for (int i = 1; i <= 62; i++) begin
      frame(K_L, 10'd1, 2'd1, 1'b0, 1'b1);
      chk("nowall_left x", 32'(player_x), 32'(134 - 2 * i));
    end
    expect_out("screen_min", 10, F_FWD, 3, S_ACTIVE);
    frame(K_L, 10'd1, 2'd1, 1'b0, 1'b1); expect_out("screen_min_hold", 10, F_FWD, 3, S_ACTIVE);
    // Below the wall after a level change: right moves normally, left snaps to the wall.
    frame(K_R, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("below_wall_r", 12, F_RIGHT, 3, S_ACTIVE);
    frame(K_L, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("snap", 130, F_FWD, 3, S_ACTIVE);
    // Right edge: 590-43 = 547.
    for (int i = 1; i <= 208; i++) begin
      frame(K_R, 10'd5, 2'd1, 1'b0, 1'b1);
      chk("walk_right x", 32'(player_x), 32'(130 + 2 * i));
    end
    chk("walk_right facing", 32'(facing), 32'(F_RIGHT));
    frame(K_R, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("xmax1", 547, F_FWD, 3, S_ACTIVE);
    frame(K_R, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("xmax2", 547, F_FWD, 3, S_ACTIVE);
    frame(K_L, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("from_max_l", 545, F_LEFT, 3, S_ACTIVE);
    frame(K_LR, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("both_keys", 543, F_LEFT, 3, S_ACTIVE);
    frame(K_R, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("r_545", 545, F_RIGHT, 3, S_ACTIVE);
    frame(K_R, 10'd5, 2'd1, 1'b0, 1'b1); expect_out("r_547", 547, F_FWD, 3, S_ACTIVE);

    // First hit: 60 frozen frames, then 120 invulnerable frames.
    frame(K_NONE, 10'd1, 2'd1, 1'b1, 1'b1); expect_out("hit1", 547, F_FWD, 2, S_HIT);
    for (int i = 1; i <= 59; i++) begin
      frame(K_L, 10'd1, 2'd1, 1'b1, 1'b1);
      expect_out($sformatf("freeze%0d", i), 547, F_FWD, 2, S_HIT);
    end
    frame(K_NONE, 10'd1, 2'd1, 1'b1, 1'b1);
    expect_out("inv_entry", 547, F_FWD, 2, S_INVULN);
    chk("inv_entry blink", 32'(blink), 32'd1);
    ex_x = 547;
    for (int i = 1; i <= 119; i++) begin
      ex_t = 119 - i;
      if (i == 5) begin
        frame(K_L, 10'd1, 2'd1, 1'b1, 1'b1);
        ex_x = 545;
        expect_out("inv_move", ex_x, F_LEFT, 2, S_INVULN);
      end else begin
        frame(K_NONE, 10'd1, 2'd1, 1'b1, 1'b1);
        expect_out($sformatf("inv%0d", i), ex_x, F_FWD, 2, S_INVULN);
      end
      chk($sformatf("inv%0d blink", i), 32'(blink), 32'((ex_t >> 2) & 1));
    end
    frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1); expect_out("back_active", 545, F_FWD, 2, S_ACTIVE);

    // Second hit, run through the whole cycle.
    frame(K_NONE, 10'd1, 2'd1, 1'b1, 1'b1); expect_out("hit2", 545, F_FWD, 1, S_HIT);
    for (int i = 1; i <= 59; i++) frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1);
    chk("hit2 last freeze", 32'(pstate), 32'(S_HIT));
    frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1);
    chk("hit2 to invuln", 32'(pstate), 32'(S_INVULN));
    for (int i = 1; i <= 119; i++) frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1);
    chk("hit2 last invuln", 32'(pstate), 32'(S_INVULN));
    frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1); expect_out("hit2 active", 545, F_FWD, 1, S_ACTIVE);

    // Last life: death, frozen, then game off restores spawn values.
    frame(K_NONE, 10'd1, 2'd1, 1'b1, 1'b1); expect_out("death", 545, F_FWD, 0, S_DEAD);
    frame(K_L, 10'd1, 2'd1, 1'b1, 1'b1);    expect_out("dead_hold1", 545, F_FWD, 0, S_DEAD);
    frame(K_R, 10'd1, 2'd1, 1'b0, 1'b1);    expect_out("dead_hold2", 545, F_FWD, 0, S_DEAD);
    frame(K_NONE, 10'd1, 2'd0, 1'b0, 1'b1); expect_out("game_off", 380, F_FWD, 3, S_IDLE);

    // Reset asserted mid-invulnerability.
    frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1); expect_out("restart", 380, F_FWD, 3, S_ACTIVE);
    frame(K_NONE, 10'd1, 2'd1, 1'b1, 1'b1); expect_out("hit3", 380, F_FWD, 2, S_HIT);
    for (int i = 1; i <= 60; i++) frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1);
    frame(K_L, 10'd1, 2'd1, 1'b0, 1'b1);
    frame(K_L, 10'd1, 2'd1, 1'b0, 1'b1);
    expect_out("pre_reset", 376, F_LEFT, 2, S_INVULN);
    keycodes = K_NONE;
    #3 Reset = 1'b1;
    #1 expect_out("async_reset", 380, F_FWD, 3, S_IDLE);
    #1 Reset = 1'b0;
    frame(K_NONE, 10'd1, 2'd1, 1'b0, 1'b1); expect_out("post_reset", 380, F_FWD, 3, S_ACTIVE);
    frame(K_L, 10'd1, 2'd1, 1'b0, 1'b1);    expect_out("post_reset_hit_free", 378, F_LEFT, 3, S_ACTIVE);

    // Disabled player: keys and collisions have no effect.
    frame(K_L, 10'd1, 2'd1, 1'b1, 1'b0); expect_out("disabled1", 378, F_FWD, 3, S_ACTIVE);
    frame(K_R, 10'd1, 2'd1, 1'b1, 1'b0); expect_out("disabled2", 378, F_FWD, 3, S_ACTIVE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
